// File: rtl/fpu_op_sequencer.sv
// Sequences one multi-cycle FP ALU op at a time: start pulse, latency count, register-file writeback.
// Optional FPU_DONE_HS_EN: EXEC exits on the FP ALU's fpu_done handshake instead of the latency counter.
module fpu_op_sequencer #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic [2:0] issue_op,
  input  logic [4:0] issue_dst,
  output logic       issue_ready,
  output logic       cpu_stall,
  output logic       fpu_start,
  output logic [2:0] fpu_op,
  input  logic       fpu_done,
  output logic       wb_en,
  output logic [4:0] wb_addr,
  output logic       busy,
  output logic       illegal_op
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             legal;
  logic             exec_exit;

  function automatic logic [CNT_W-1:0] lat_m1(input logic [1:0] op);
    case (op)
      2'd0:    lat_m1 = CNT_W'(ADD_LAT - 1);
      2'd1:    lat_m1 = CNT_W'(MUL_LAT - 1);
      2'd2:    lat_m1 = CNT_W'(DIV_LAT - 1);
      default: lat_m1 = CNT_W'(SQRT_LAT - 1);
    endcase
  endfunction

  assign issue_ready = (state != EXEC);
  assign cpu_stall   = issue_valid & ~issue_ready;
  assign accept      = issue_valid & issue_ready;
  assign legal       = ~issue_op[2];
  assign busy        = (state != IDLE);

`ifdef FPU_DONE_HS_EN
  assign exec_exit = fpu_done;
`else
  // Without the handshake the ALU's completion flag carries no information here.
  logic unused_fpu_done;
  assign unused_fpu_done = fpu_done;
  assign exec_exit       = (cnt == '0);
`endif

  // NOTE: every register in this block uses <= so all next-state values are computed
  // from the pre-edge state; the async reset clears the pending writeback as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      fpu_start  <= 1'b0;
      fpu_op     <= 3'd0;
      wb_en      <= 1'b0;
      wb_addr    <= 5'd0;
      illegal_op <= 1'b0;
    end else begin
      fpu_start  <= 1'b0;
      wb_en      <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        IDLE, WB: begin
          state <= IDLE;
          if (accept) begin
            if (legal) begin
              state     <= EXEC;
              fpu_op    <= issue_op;
              wb_addr   <= issue_dst;
              cnt       <= lat_m1(issue_op[1:0]);
              fpu_start <= 1'b1;
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        EXEC: begin
          // Saturate at zero so a late handshake cannot wrap the counter.
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (exec_exit) begin
            state <= WB;
            wb_en <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: vector table plus hand sequences, scoreboarded events.
module tb_fpu_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic [2:0] issue_op;
  logic [4:0] issue_dst;
  logic       issue_ready;
  logic       cpu_stall;
  logic       fpu_start;
  logic [2:0] fpu_op;
  logic       fpu_done;
  logic       wb_en;
  logic [4:0] wb_addr;
  logic       busy;
  logic       illegal_op;

  fpu_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_op   (issue_op),
    .issue_dst  (issue_dst),
    .issue_ready(issue_ready),
    .cpu_stall  (cpu_stall),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_done   (fpu_done),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .busy       (busy),
    .illegal_op (illegal_op)
  );

  typedef struct {
    int cyc;
    int addr;
    int op;
  } ev_t;

  typedef struct {
    logic [2:0] op;
    logic [4:0] dst;
    int         lat;  // 0 marks an illegal op
  } vec_t;

  ev_t sb_start[$];
  ev_t sb_wb[$];
  ev_t sb_ill[$];
  ev_t ev_mon;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int resp_lat = 1;
  int resp_cnt = -1;
  bit resp_en  = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Stand-in FP ALU completion signal.
  initial begin
    fpu_done = 1'b0;
    forever begin
      @(negedge clk);
`ifdef FPU_DONE_HS_EN
      if (resp_en) begin
        if (fpu_start) resp_cnt = resp_lat - 1;
        else if (resp_cnt >= 0) resp_cnt--;
        fpu_done = (resp_cnt == 0);
      end
`else
      fpu_done = 1'($urandom_range(0, 1));
`endif
    end
  end

  // Event monitor: every start/writeback/illegal pulse must match the front of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fpu_start) begin
        if (sb_start.size() == 0) check("unexpected fpu_start", 1, 0);
        else begin
          ev_mon = sb_start.pop_front();
          check("fpu_start cycle", cyc, ev_mon.cyc);
          check("fpu_op at start", int'(fpu_op), ev_mon.op);
        end
      end
      if (wb_en) begin
        if (sb_wb.size() == 0) check("unexpected wb_en", 1, 0);
        else begin
          ev_mon = sb_wb.pop_front();
          check("wb_en cycle", cyc, ev_mon.cyc);
          check("wb_addr", int'(wb_addr), ev_mon.addr);
          check("fpu_op held to wb", int'(fpu_op), ev_mon.op);
        end
      end
      if (illegal_op) begin
        if (sb_ill.size() == 0) check("unexpected illegal_op", 1, 0);
        else begin
          ev_mon = sb_ill.pop_front();
          check("illegal_op cycle", cyc, ev_mon.cyc);
          check("issue_ready after illegal", int'(issue_ready), 1);
          check("no fpu_start with illegal", int'(fpu_start), 0);
        end
      end
    end
  end

  // Called at a negedge; holds the op until accepted, returns at the next negedge with valid low.
  task automatic issue(input logic [2:0] op, input logic [4:0] dst, input int lat,
                       output int stalls);
    int guard;
    int acc;
    stalls      = 0;
    guard       = 0;
    issue_valid = 1'b1;
    issue_op    = op;
    issue_dst   = dst;
    while (!issue_ready && guard < 64) begin
      stalls++;
      check("cpu_stall while exec", int'(cpu_stall), 1);
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check("accept timeout", guard, 0);
    check("cpu_stall at accept", int'(cpu_stall), 0);
    acc      = cyc;
    resp_lat = lat;
    if (lat > 0) begin
      sb_start.push_back('{cyc: acc + 1, addr: 0, op: int'(op)});
      sb_wb.push_back('{cyc: acc + lat + 1, addr: int'(dst), op: int'(op)});
    end else begin
      sb_ill.push_back('{cyc: acc + 1, addr: 0, op: 0});
    end
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  vec_t vecs[8];
  int   st;

  initial begin
    vecs[0] = '{op: 3'd0, dst: 5'd7,  lat: 2};
    vecs[1] = '{op: 3'd1, dst: 5'd5,  lat: 3};
    vecs[2] = '{op: 3'd2, dst: 5'd4,  lat: 12};
    vecs[3] = '{op: 3'd3, dst: 5'd31, lat: 16};
    vecs[4] = '{op: 3'd4, dst: 5'd1,  lat: 0};
    vecs[5] = '{op: 3'd7, dst: 5'd2,  lat: 0};
    vecs[6] = '{op: 3'd1, dst: 5'd0,  lat: 3};
    vecs[7] = '{op: 3'd6, dst: 5'd9,  lat: 0};

    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = 3'd0;
    issue_dst   = 5'd0;
    repeat (2) @(negedge clk);
    check("reset fpu_start", int'(fpu_start), 0);
    check("reset fpu_op", int'(fpu_op), 0);
    check("reset wb_en", int'(wb_en), 0);
    check("reset wb_addr", int'(wb_addr), 0);
    check("reset busy", int'(busy), 0);
    check("reset illegal_op", int'(illegal_op), 0);
    check("reset issue_ready", int'(issue_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // add.s: busy spans cycles 1..3 after acceptance
    issue(3'd0, 5'd7, 2, st);
    check("add stalls", st, 0);
    for (int k = 1; k <= 4; k++) begin
      check("add busy", int'(busy), (k <= 3) ? 1 : 0);
      if (k < 4) @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].dst, vecs[i].lat, st);
      if (vecs[i].lat == 0) check("ready after illegal", int'(issue_ready), 1);
      repeat (vecs[i].lat + 2) @(negedge clk);
    end
    check("start queue drained", sb_start.size(), 0);
    check("wb queue drained", sb_wb.size(), 0);
    check("illegal queue drained", sb_ill.size(), 0);

    // div.s then mul.s held valid: stalled through EXEC, accepted on the WB edge
    issue(3'd2, 5'd4, 12, st);
    issue(3'd1, 5'd5, 3, st);
    check("div->mul stall cycles", st, 12);
    repeat (6) @(negedge clk);

    // illegal op accepted on a WB edge
    issue(3'd0, 5'd9, 2, st);
    repeat (2) @(negedge clk);
    issue(3'd5, 5'd3, 0, st);
    check("idle after illegal in wb", int'(busy), 0);
    repeat (3) @(negedge clk);

    // sqrt.s aborted by reset in cycle 8
    issue(3'd3, 5'd12, 16, st);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort fpu_start", int'(fpu_start), 0);
    check("abort fpu_op", int'(fpu_op), 0);
    check("abort wb_en", int'(wb_en), 0);
    check("abort wb_addr", int'(wb_addr), 0);
    check("abort busy", int'(busy), 0);
    check("abort issue_ready", int'(issue_ready), 1);
    sb_wb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort busy after release", int'(busy), 0);

`ifdef FPU_DONE_HS_EN
    // div.s finishing early on the handshake: done in cycle 4, writeback in cycle 5
    resp_en  = 1'b0;
    fpu_done = 1'b0;
    issue(3'd2, 5'd4, 4, st);
    repeat (3) @(negedge clk);
    fpu_done = 1'b1;
    @(negedge clk);
    fpu_done = 1'b0;
    repeat (3) @(negedge clk);
    resp_en = 1'b1;
`endif

    check("final start queue", sb_start.size(), 0);
    check("final wb queue", sb_wb.size(), 0);
    check("final illegal queue", sb_ill.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
